train_sensor_emulator: RTL and testbench

Generates the track-sensor pulse stream that the train controller consumes on its six sensor inputs, emulating a train passing sensors 1..6 in sequence. It drives a programmable inter-sensor gap, either direction, and single-run or looping laps. It is used on the board as a stimulus source in place of physical sensors, and in benches as the transmitter end of the sensor interface. It runs on the same divided clock as the controller.

---
 rtl/train_sensor_emulator.sv | 148 ++++++++++++++
 tb/tb_train_sensor_emulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/train_sensor_emulator.sv
// Emulates a train passing track sensors S1..S6: one pulse per sensor, a programmable gap
// between pulses, either direction, single run or looping laps. All outputs are registered.
module train_sensor_emulator #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_W     = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [GAP_W-1:0] seg_ticks,
    input  logic             dir,
    input  logic             loop,
    output logic [5:0]       sensors,
    output logic [2:0]       sensor_idx,
    output logic             busy,
    output logic             done,
    output logic [7:0]       lap_count
);

    localparam int unsigned PcW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [PcW-1:0]   pcnt_q, pcnt_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [GAP_W-1:0] seg_q, seg_d;
    logic             dir_q, dir_d;
    logic             loop_q, loop_d;
    logic [7:0]       lap_q, lap_d;
    logic [5:0]       sensors_q, sensors_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             last_pulse;
    logic [2:0]       end_idx;
    logic [2:0]       first_idx;

    assign last_pulse = (pcnt_q == PcW'(PULSE_LEN - 1));
    assign end_idx    = dir_q ? 3'd0 : 3'd5;
    assign first_idx  = dir_q ? 3'd5 : 3'd0;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            pcnt_q    <= '0;
            gcnt_q    <= '0;
            seg_q     <= '0;
            dir_q     <= 1'b0;
            loop_q    <= 1'b0;
            lap_q     <= '0;
            sensors_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pcnt_q    <= pcnt_d;
            gcnt_q    <= gcnt_d;
            seg_q     <= seg_d;
            dir_q     <= dir_d;
            loop_q    <= loop_d;
            lap_q     <= lap_d;
            sensors_q <= sensors_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        gcnt_d  = gcnt_q;
        seg_d   = seg_q;
        dir_d   = dir_q;
        loop_d  = loop_q;
        lap_d   = lap_q;
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort && (seg_ticks != '0)) begin
                        seg_d   = seg_ticks;
                        dir_d   = dir;
                        loop_d  = loop;
                        idx_d   = dir ? 3'd5 : 3'd0;
                        lap_d   = '0;
                        pcnt_d  = '0;
                        state_d = StPulse;
                    end
                end
                StPulse: begin
                    if (last_pulse) begin
                        pcnt_d = '0;
                        gcnt_d = seg_q;
                        if (idx_q != end_idx) begin
                            idx_d   = dir_q ? idx_q - 3'd1 : idx_q + 3'd1;
                            state_d = StGap;
                        end else if (loop_q) begin
                            lap_d   = lap_q + 8'd1;
                            idx_d   = first_idx;
                            state_d = StGap;
                        end else begin
                            lap_d   = lap_q + 8'd1;
                            state_d = StDone;
                        end
                    end else begin
                        pcnt_d = pcnt_q + PcW'(1);
                    end
                end
                StGap: begin
                    // Counter was loaded with a non-zero gap, so the exit test is at 1
                    if (gcnt_q == GAP_W'(1)) begin
                        state_d = StPulse;
                    end else begin
                        gcnt_d = gcnt_q - GAP_W'(1);
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are computed from the next state so the registered values line up with it
    always_comb begin
        sensors_d = '0;
        if (state_d == StPulse) begin
            sensors_d = 6'b000001 << idx_d;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    assign sensors    = sensors_q;
    assign sensor_idx = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign lap_count  = lap_q;

endmodule

// File: tb/tb_train_sensor_emulator.sv
// Directed self-checking bench for train_sensor_emulator; a second small-gap instance
// exercises the all-ones gap value.
module tb_train_sensor_emulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, dir, loop;
    logic [18:0] seg_ticks;
    logic [5:0]  sensors;
    logic [2:0]  sensor_idx;
    logic        busy, done;
    logic [7:0]  lap_count;

    logic        start_m, abort_m;
    logic [5:0]  seg_m;
    logic [5:0]  sensors_m;
    logic [2:0]  idx_m;
    logic        busy_m, done_m;
    logic [7:0]  lap_m;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    train_sensor_emulator #(.PULSE_LEN(4), .GAP_W(19)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seg_ticks  (seg_ticks),
        .dir        (dir),
        .loop       (loop),
        .sensors    (sensors),
        .sensor_idx (sensor_idx),
        .busy       (busy),
        .done       (done),
        .lap_count  (lap_count)
    );

    train_sensor_emulator #(.PULSE_LEN(2), .GAP_W(6)) u_max (
        .clk        (clk),
        .rst        (rst),
        .start      (start_m),
        .abort      (abort_m),
        .seg_ticks  (seg_m),
        .dir        (1'b0),
        .loop       (1'b0),
        .sensors    (sensors_m),
        .sensor_idx (idx_m),
        .busy       (busy_m),
        .done       (done_m),
        .lap_count  (lap_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] onehot6(input int i);
        logic [5:0] one;
        one = 6'b000001;
        return one << i;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("onehot", {31'b0, $countones(sensors) <= 1}, 32'd1);
            check("onehot_m", {31'b0, $countones(sensors_m) <= 1}, 32'd1);
        end
    end

    // One non-looping run with PULSE_LEN=4; cycle 1 is the first cycle after start is sampled
    task automatic run_single(input int g, input logic d, input bit disturb);
        int last, period, k, off, pk;
        logic [5:0] exp_s;
        logic [2:0] exp_i;
        period = 4 + g;
        last   = 6 * 4 + 5 * g + 1;
        seg_ticks = 19'(g);
        dir   = d;
        loop  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            k   = (c - 1) / period;
            off = (c - 1) % period;
            exp_s = (k < 6 && off < 4) ? onehot6(d ? 5 - k : k) : 6'b0;
            pk = (c == last) ? 5 : ((off < 4) ? k : k + 1);
            exp_i = 3'(d ? 5 - pk : pk);
            check("sensors", {26'b0, sensors}, {26'b0, exp_s});
            check("done", {31'b0, done}, {31'b0, c == last});
            check("busy", {31'b0, busy}, {31'b0, c <= last});
            if (c <= last) check("sensor_idx", {29'b0, sensor_idx}, {29'b0, exp_i});
            if (disturb && c == 20) begin
                start = 1'b1;
                seg_ticks = 19'd5;
                dir  = ~d;
                loop = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        check("lap_single", {24'b0, lap_count}, 32'd1);
        loop = 1'b0;
    endtask

    initial begin
        int k, off, cnt;
        logic [5:0] exp_s;
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0; loop = 1'b0; seg_ticks = '0;
        start_m = 1'b0; abort_m = 1'b0; seg_m = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_sensors", {26'b0, sensors}, 32'd0);
        check("rst_idx", {29'b0, sensor_idx}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_lap", {24'b0, lap_count}, 32'd0);

        // start with zero gap is ignored
        seg_ticks = '0; start = 1'b1;
        step();
        start = 1'b0;
        check("zero_gap_busy", {31'b0, busy}, 32'd0);
        step();
        check("zero_gap_busy2", {31'b0, busy}, 32'd0);

        // start and abort together in IDLE: abort wins
        seg_ticks = 19'd10; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", {31'b0, busy}, 32'd0);
        check("start_abort_sens", {26'b0, sensors}, 32'd0);

        run_single(10, 1'b0, 1'b0);
        run_single(3, 1'b1, 1'b0);

        // Reset in the middle of the first gap
        seg_ticks = 19'd10; dir = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("mid_gap_sens", {26'b0, sensors}, 32'd0);
        check("mid_gap_busy", {31'b0, busy}, 32'd1);
        check("mid_gap_idx", {29'b0, sensor_idx}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_idx", {29'b0, sensor_idx}, 32'd0);
        check("rst_mid_lap", {24'b0, lap_count}, 32'd0);
        // Rerun forward, with a stray start and changed inputs mid-run
        run_single(10, 1'b0, 1'b1);

        // Looping run, abort during the S3 pulse of lap 4
        seg_ticks = 19'd2; dir = 1'b0; loop = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 122; c++) begin
            k   = (c - 1) / 6;
            off = (c - 1) % 6;
            exp_s = (off < 4) ? onehot6(k % 6) : 6'b0;
            check("loop_sensors", {26'b0, sensors}, {26'b0, exp_s});
            check("loop_lap", {24'b0, lap_count}, 32'((c + 1) / 36));
            check("loop_done", {31'b0, done}, 32'd0);
            if (c == 122) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        check("abort_sens", {26'b0, sensors}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_lap", {24'b0, lap_count}, 32'd3);
        step();
        check("abort_done2", {31'b0, done}, 32'd0);

        // All-ones gap on the 6-bit instance
        seg_m = 6'h3F; start_m = 1'b1;
        step();
        start_m = 1'b0;
        check("max_s1_a", {26'b0, sensors_m}, 32'd1);
        step();
        check("max_s1_b", {26'b0, sensors_m}, 32'd1);
        step();
        cnt = 0;
        while (sensors_m == 6'b0 && cnt < 200) begin
            cnt++;
            step();
        end
        check("max_gap_len", 32'(cnt), 32'd63);
        check("max_s2", {26'b0, sensors_m}, 32'd2);
        abort_m = 1'b1;
        step();
        abort_m = 1'b0;
        check("max_abort_busy", {31'b0, busy_m}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
